// File: rtl/bram_port_arbiter.sv
// Two-master round-robin arbiter in front of a single-port BRAM. One access per
// cycle is issued through a register stage; reads are tagged so data returns to its owner.
module bram_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clka_0,
  input  logic              rstn_0,
  input  logic              req_0,
  input  logic              req_1,
  input  logic              we_0,
  input  logic              we_1,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [DATA_W-1:0] wdata_0,
  input  logic [DATA_W-1:0] wdata_1,
  output logic              gnt_0,
  output logic              gnt_1,
  output logic              rvalid_0,
  output logic              rvalid_1,
  output logic [DATA_W-1:0] rdata_0,
  output logic [DATA_W-1:0] rdata_1,
  output logic [ADDR_W-1:0] addra_0,
  output logic [DATA_W-1:0] dina_0,
  output logic              wea_0,
  input  logic [DATA_W-1:0] douta_0
);

  logic              r_last;      // 1 = requester 1 holds the most recent grant
  logic [ADDR_W-1:0] r_addra;
  logic [DATA_W-1:0] r_dina;
  logic              r_wea;
  logic [RD_LAT:0]   r_vld_pipe;
  logic [RD_LAT:0]   r_own_pipe;
  logic              w_gnt_0;
  logic              w_gnt_1;
  logic              w_rd_issue;

  // Grants are masked by reset so nothing is accepted while the issue stage is held clear.
  assign w_gnt_0    = rstn_0 & req_0 & (~req_1 | r_last);
  assign w_gnt_1    = rstn_0 & req_1 & (~req_0 | ~r_last);
  assign w_rd_issue = (w_gnt_0 & ~we_0) | (w_gnt_1 & ~we_1);

  always_ff @(posedge clka_0 or negedge rstn_0) begin
    if (!rstn_0) begin
      r_last  <= 1'b1;
      r_addra <= '0;
      r_dina  <= '0;
      r_wea   <= 1'b0;
    end else begin
      r_wea <= 1'b0;
      if (w_gnt_0) begin
        r_last  <= 1'b0;
        r_addra <= addr_0;
        r_dina  <= wdata_0;
        r_wea   <= we_0;
      end else if (w_gnt_1) begin
        r_last  <= 1'b1;
        r_addra <= addr_1;
        r_dina  <= wdata_1;
        r_wea   <= we_1;
      end
    end
  end

  // Stage 0 covers the issue register; stage RD_LAT lines up with douta_0.
  always_ff @(posedge clka_0 or negedge rstn_0) begin
    if (!rstn_0) begin
      r_vld_pipe <= '0;
      r_own_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[RD_LAT-1:0], w_rd_issue};
      r_own_pipe <= {r_own_pipe[RD_LAT-1:0], w_gnt_1};
    end
  end

  assign gnt_0    = w_gnt_0;
  assign gnt_1    = w_gnt_1;
  assign rvalid_0 = r_vld_pipe[RD_LAT] & ~r_own_pipe[RD_LAT];
  assign rvalid_1 = r_vld_pipe[RD_LAT] &  r_own_pipe[RD_LAT];
  assign rdata_0  = douta_0;
  assign rdata_1  = douta_0;
  assign addra_0  = r_addra;
  assign dina_0   = r_dina;
  assign wea_0    = r_wea;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: two instances (RD_LAT=1 and 2) share stimulus, each
// driving its own BRAM model; a negedge monitor scores grants and read returns.
module tb_bram_port_arbiter;

  logic        clk, rstn;
  logic        req_0, req_1, we_0, we_1;
  logic [9:0]  addr_0, addr_1;
  logic [15:0] wdata_0, wdata_1;

  logic        gnt_0_a, gnt_1_a, rvalid_0_a, rvalid_1_a, wea_a;
  logic [15:0] rdata_0_a, rdata_1_a, dina_a, douta_a;
  logic [9:0]  addra_a;
  logic        gnt_0_b, gnt_1_b, rvalid_0_b, rvalid_1_b, wea_b;
  logic [15:0] rdata_0_b, rdata_1_b, dina_b, douta_b;
  logic [9:0]  addra_b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bram_port_arbiter #(.ADDR_W(10), .DATA_W(16), .RD_LAT(1)) dut_a (
    .clka_0(clk), .rstn_0(rstn), .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .gnt_0(gnt_0_a), .gnt_1(gnt_1_a), .rvalid_0(rvalid_0_a), .rvalid_1(rvalid_1_a),
    .rdata_0(rdata_0_a), .rdata_1(rdata_1_a), .addra_0(addra_a), .dina_0(dina_a),
    .wea_0(wea_a), .douta_0(douta_a));

  bram_port_arbiter #(.ADDR_W(10), .DATA_W(16), .RD_LAT(2)) dut_b (
    .clka_0(clk), .rstn_0(rstn), .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .addr_0(addr_0), .addr_1(addr_1), .wdata_0(wdata_0), .wdata_1(wdata_1),
    .gnt_0(gnt_0_b), .gnt_1(gnt_1_b), .rvalid_0(rvalid_0_b), .rvalid_1(rvalid_1_b),
    .rdata_0(rdata_0_b), .rdata_1(rdata_1_b), .addra_0(addra_b), .dina_0(dina_b),
    .wea_0(wea_b), .douta_0(douta_b));

  // BRAM models: read-first, RD_LAT register stages on the output
  logic [15:0] mem_a [1024];
  logic [15:0] mem_b [1024];
  logic [15:0] qb1;
  always @(posedge clk) begin
    if (wea_a) mem_a[addra_a] <= dina_a;
    douta_a <= mem_a[addra_a];
    if (wea_b) mem_b[addra_b] <= dina_b;
    qb1     <= mem_b[addra_b];
    douta_b <= qb1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard: expected read returns queued at grant time, popped on rvalid
  typedef struct {
    logic        own;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t        sb [2][$];
  logic [15:0] ref_mem [1024];
  logic        m_last = 1'b1;

  initial forever begin
    logic        eg0, eg1, gw, rv0, rv1;
    logic [9:0]  ga;
    logic [15:0] gd, rd0, rd1;
    exp_t        e;
    @(negedge clk);
    if (!rstn) begin
      checks++;
      if ({gnt_0_a, gnt_1_a, gnt_0_b, gnt_1_b, rvalid_0_a, rvalid_1_a, rvalid_0_b, rvalid_1_b} !== 8'h00) begin
        errors++;
        $display("FAIL reset_quiet cyc=%0d got gnt a=%b%b b=%b%b rv a=%b%b b=%b%b want all 0", cyc,
                 gnt_1_a, gnt_0_a, gnt_1_b, gnt_0_b, rvalid_1_a, rvalid_0_a, rvalid_1_b, rvalid_0_b);
      end
      m_last = 1'b1;
      sb[0].delete();
      sb[1].delete();
    end else begin
      eg0 = req_0 & (~req_1 | m_last);
      eg1 = req_1 & (~req_0 | ~m_last);
      checks++;
      if ({gnt_1_a, gnt_0_a, gnt_1_b, gnt_0_b} !== {eg1, eg0, eg1, eg0}) begin
        errors++;
        $display("FAIL grant cyc=%0d got a=%b%b b=%b%b want %b%b", cyc,
                 gnt_1_a, gnt_0_a, gnt_1_b, gnt_0_b, eg1, eg0);
      end
      for (int d = 0; d < 2; d++) begin
        rv0 = (d == 0) ? rvalid_0_a : rvalid_0_b;
        rv1 = (d == 0) ? rvalid_1_a : rvalid_1_b;
        rd0 = (d == 0) ? rdata_0_a : rdata_0_b;
        rd1 = (d == 0) ? rdata_1_a : rdata_1_b;
        if (rv0 | rv1) begin
          checks++;
          if (sb[d].size() == 0) begin
            errors++;
            $display("FAIL rvalid_spurious dut=%0d cyc=%0d got rv=%b%b want none", d, cyc, rv1, rv0);
          end else begin
            e = sb[d].pop_front();
            if ({rv1, rv0} !== {e.own, ~e.own} || e.due != cyc || (e.own ? rd1 : rd0) !== e.data) begin
              errors++;
              $display("FAIL read_return dut=%0d cyc=%0d got rv=%b%b data=%h want own=%0d data=%h at cyc %0d",
                       d, cyc, rv1, rv0, e.own ? rd1 : rd0, e.own, e.data, e.due);
            end
          end
        end
        while (sb[d].size() > 0 && sb[d][0].due < cyc) begin
          e = sb[d].pop_front();
          checks++;
          errors++;
          $display("FAIL rvalid_missing dut=%0d got none want own=%0d data=%h at cyc %0d", d, e.own, e.data, e.due);
        end
      end
      if (eg0 | eg1) begin
        gw = eg0 ? we_0 : we_1;
        ga = eg0 ? addr_0 : addr_1;
        gd = eg0 ? wdata_0 : wdata_1;
        if (gw) ref_mem[ga] = gd;
        else begin
          sb[0].push_back('{own: eg1, data: ref_mem[ga], due: cyc + 2});
          sb[1].push_back('{own: eg1, data: ref_mem[ga], due: cyc + 3});
        end
        m_last = eg1;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit k, input bit w, input logic [9:0] a, input logic [15:0] d);
    if (k == 1'b0) begin req_0 = 1'b1; we_0 = w; addr_0 = a; wdata_0 = d; end
    else           begin req_1 = 1'b1; we_1 = w; addr_1 = a; wdata_1 = d; end
    step();
    req_0 = 1'b0;
    req_1 = 1'b0;
  endtask

  task automatic test_reset();
    req_0 = 1'b1; req_1 = 1'b1;
    #2;
    checks++;
    if ({gnt_0_a, gnt_1_a, wea_a, rvalid_0_a, rvalid_1_a} !== 5'b0 || addra_a !== 10'd0 || dina_a !== 16'd0 ||
        {gnt_0_b, gnt_1_b, wea_b, rvalid_0_b, rvalid_1_b} !== 5'b0 || addra_b !== 10'd0 || dina_b !== 16'd0) begin
      errors++;
      $display("FAIL reset_values got gnt=%b%b wea=%b addra=%0d dina=%h rv=%b%b want all zero",
               gnt_1_a, gnt_0_a, wea_a, addra_a, dina_a, rvalid_1_a, rvalid_0_a);
    end
    step();
    req_0 = 1'b0; req_1 = 1'b0;
    rstn = 1'b1;
  endtask

  task automatic test_write_read();
    req_0 = 1'b1; we_0 = 1'b1; addr_0 = 10'd2; wdata_0 = 16'd23;
    step();
    req_0 = 1'b0;
    #1;
    checks++;
    if (wea_a !== 1'b1 || addra_a !== 10'd2 || dina_a !== 16'd23 || wea_b !== 1'b1 || addra_b !== 10'd2) begin
      errors++;
      $display("FAIL write_issue got wea=%b addra=%0d dina=%0d want 1 2 23", wea_a, addra_a, dina_a);
    end
    step();
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 10'd2;
    step();
    req_0 = 1'b0;
    #1;
    checks++;
    if (wea_a !== 1'b0 || addra_a !== 10'd2) begin
      errors++;
      $display("FAIL read_issue got wea=%b addra=%0d want 0 2", wea_a, addra_a);
    end
    step();
    checks++;
    if (rvalid_0_a !== 1'b1 || rdata_0_a !== 16'd23 || rvalid_1_a !== 1'b0) begin
      errors++;
      $display("FAIL read_lat1 got rv=%b%b rdata_0=%0d want 01 23", rvalid_1_a, rvalid_0_a, rdata_0_a);
    end
    step();
    checks++;
    if (rvalid_0_b !== 1'b1 || rdata_0_b !== 16'd23 || rvalid_0_a !== 1'b0) begin
      errors++;
      $display("FAIL read_lat2 got rv_b=%b rdata_b=%0d rv_a=%b want 1 23 0", rvalid_0_b, rdata_0_b, rvalid_0_a);
    end
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 1'b1, 10'd3, 16'd45);
    req_1 = 1'b1; we_1 = 1'b1; addr_1 = 10'd1; wdata_1 = 16'd50;
    step();
    we_1 = 1'b0;
    #1;
    checks++;
    if (wea_a !== 1'b1 || addra_a !== 10'd1 || dina_a !== 16'd50 || gnt_1_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_write got wea=%b addra=%0d dina=%0d gnt_1=%b want 1 1 50 1", wea_a, addra_a, dina_a, gnt_1_a);
    end
    step();
    req_1 = 1'b0;
    #1;
    checks++;
    if (wea_a !== 1'b0 || addra_a !== 10'd1) begin
      errors++;
      $display("FAIL b2b_read_issue got wea=%b addra=%0d want 0 1", wea_a, addra_a);
    end
    step();
    checks++;
    if (rvalid_1_a !== 1'b1 || rdata_1_a !== 16'd50 || rvalid_0_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_read_data got rv=%b%b rdata_1=%0d want 10 50", rvalid_1_a, rvalid_0_a, rdata_1_a);
    end
    step();
  endtask

  task automatic test_contention();
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 10'd3;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 10'd1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) begin req_0 = 1'b0; req_1 = 1'b0; end
      #1;
      if (i < 4) begin
        checks++;
        if (gnt_0_a !== (i % 2 == 0) || gnt_1_a !== (i % 2 == 1)) begin
          errors++;
          $display("FAIL contention_gnt i=%0d got %b%b want %b%b", i, gnt_1_a, gnt_0_a, i % 2 == 1, i % 2 == 0);
        end
      end
      if (i >= 2) begin
        checks++;
        if (rvalid_0_a !== (i % 2 == 0) || rvalid_1_a !== (i % 2 == 1) ||
            rdata_0_a !== ((i % 2 == 0) ? 16'd45 : 16'd50)) begin
          errors++;
          $display("FAIL contention_rv i=%0d got rv=%b%b data=%0d want %b%b %0d", i, rvalid_1_a, rvalid_0_a,
                   rdata_0_a, i % 2 == 1, i % 2 == 0, (i % 2 == 0) ? 45 : 50);
        end
      end
      step();
    end
  endtask

  task automatic test_withdrawn();
    req_0 = 1'b1; we_0 = 1'b0; addr_0 = 10'd2;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 10'd3;
    #1;
    checks++;
    if (gnt_0_a !== 1'b1 || gnt_1_a !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_first got %b%b want 01", gnt_1_a, gnt_0_a);
    end
    step();
    req_0 = 1'b0; req_1 = 1'b0;
    step();
    req_0 = 1'b1; addr_0 = 10'd3;
    req_1 = 1'b1; addr_1 = 10'd2;
    #1;
    checks++;
    if (gnt_1_a !== 1'b1 || gnt_0_a !== 1'b0) begin
      errors++;
      $display("FAIL withdraw_tie got %b%b want 10", gnt_1_a, gnt_0_a);
    end
    step();
    req_1 = 1'b0;
    step();
    req_0 = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 1'b0, 10'd2, 16'd0);
    req_0 = 1'b1; addr_0 = 10'd3;
    req_1 = 1'b1; we_1 = 1'b0; addr_1 = 10'd1;
    rstn = 1'b0;
    #1;
    checks++;
    if ({gnt_0_a, gnt_1_a, wea_a, rvalid_0_a, rvalid_1_a, gnt_0_b, gnt_1_b} !== 7'b0 ||
        addra_a !== 10'd0 || dina_a !== 16'd0 || addra_b !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid_values got gnt=%b%b wea=%b addra=%0d dina=%h rv=%b%b want all zero",
               gnt_1_a, gnt_0_a, wea_a, addra_a, dina_a, rvalid_1_a, rvalid_0_a);
    end
    step();
    rstn = 1'b1;
    #1;
    checks++;
    if (gnt_0_a !== 1'b1 || gnt_1_a !== 1'b0 || rvalid_0_a !== 1'b0 || rvalid_0_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got gnt=%b%b rv_a=%b rv_b=%b want 01 0 0", gnt_1_a, gnt_0_a, rvalid_0_a, rvalid_0_b);
    end
    step();
    req_0 = 1'b0;
    #1;
    checks++;
    if (rvalid_0_a !== 1'b0 || rvalid_0_b !== 1'b0 || rvalid_1_b !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard got rv_a=%b rv_b=%b%b want 0 00", rvalid_0_a, rvalid_1_b, rvalid_0_b);
    end
    step();
    req_1 = 1'b0;
    repeat (4) step();
  endtask

  task automatic test_addr_top();
    issue(1'b1, 1'b1, 10'd1023, 16'hBEEF);
    #1;
    checks++;
    if (addra_a !== 10'd1023 || dina_a !== 16'hBEEF || wea_a !== 1'b1) begin
      errors++;
      $display("FAIL addr_top got addra=%0d dina=%h wea=%b want 1023 beef 1", addra_a, dina_a, wea_a);
    end
    issue(1'b0, 1'b0, 10'd1023, 16'd0);
    repeat (4) step();
  endtask

  task automatic test_rdlat2();
    logic [9:0]  ta [4];
    logic [15:0] td [4];
    ta[0] = 10'd3; ta[1] = 10'd1; ta[2] = 10'd2; ta[3] = 10'd1023;
    td[0] = 16'd45; td[1] = 16'd50; td[2] = 16'd23; td[3] = 16'hBEEF;
    we_0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req_0 = (i < 4);
      if (i < 4) addr_0 = ta[i];
      #1;
      if (i >= 3 && i < 7) begin
        checks++;
        if (rvalid_0_b !== 1'b1 || rdata_0_b !== td[i-3]) begin
          errors++;
          $display("FAIL rdlat2_stream i=%0d got rv=%b data=%h want 1 %h", i, rvalid_0_b, rdata_0_b, td[i-3]);
        end
      end
      step();
    end
  endtask

  initial begin
    rstn = 1'b0;
    req_0 = 1'b0; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
    addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_contention();
    test_withdrawn();
    test_reset_mid();
    test_addr_top();
    test_rdlat2();
    repeat (6) step();
    checks++;
    if (sb[0].size() != 0 || sb[1].size() != 0) begin
      errors++;
      $display("FAIL drain got pending %0d/%0d want 0/0", sb[0].size(), sb[1].size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
